// File: rtl/residual_lane_sat.sv
// Multi-lane residual adder: y = x + (sub >>> shift) over a flattened tensor,
// LANES elements per beat, run-time wrap/saturate and a sticky overflow flag.
module residual_lane_sat #(
   parameter int DATA_WIDTH = 16,
   parameter int SEQ_LEN    = 8,
   parameter int EMB_DIM    = 8,
   parameter int LANES      = 4,
   parameter int SHIFT_W    = $clog2(DATA_WIDTH)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic                                  sat_en,
   input  logic [SHIFT_W-1:0]                    sub_shift,
   input  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] x_in,
   input  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] sub_in,
   output logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] y_out,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  out_valid,
   output logic                                  ovf
);
   localparam int N         = SEQ_LEN * EMB_DIM;
   localparam int NUM_BEATS = N / LANES;
   localparam int CNT_W     = $clog2(NUM_BEATS) + 1;
   localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   generate
      if (N % LANES != 0) begin : g_bad_lanes
         $error("LANES must divide SEQ_LEN*EMB_DIM");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t                    state_reg, state_next;
   logic [CNT_W-1:0]          beat_reg;
   logic                      sat_reg;
   logic [SHIFT_W-1:0]        shift_reg;
   logic [DATA_WIDTH*N-1:0]   y_reg;
   logic                      out_valid_reg;
   logic                      ovf_reg;
   logic                      accept;
   logic                      last_beat;
   logic [DATA_WIDTH-1:0]     lane_y [LANES];
   logic [LANES-1:0]          lane_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      last_beat  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = ADD;
            end
         end
         ADD: begin
            busy = 1'b1;
            if (beat_reg == CNT_W'(NUM_BEATS - 1)) begin
               last_beat  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept     = 1'b1;
               state_next = ADD;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Each lane reads the element selected by the current beat and forms a
   // DATA_WIDTH+1 bit sum so overflow shows up as a mismatch of the top two bits.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         int                            base;
         logic signed [DATA_WIDTH-1:0]  x_e;
         logic signed [DATA_WIDTH-1:0]  s_e;
         logic        [DATA_WIDTH:0]    sum_e;

         assign base  = (int'(beat_reg) * LANES + gi) * DATA_WIDTH;
         assign x_e   = x_in[base +: DATA_WIDTH];
         assign s_e   = $signed(sub_in[base +: DATA_WIDTH]) >>> shift_reg;
         assign sum_e = {x_e[DATA_WIDTH-1], x_e} + {s_e[DATA_WIDTH-1], s_e};
         assign lane_ovf[gi] = sum_e[DATA_WIDTH] ^ sum_e[DATA_WIDTH-1];
         assign lane_y[gi]   = (lane_ovf[gi] && sat_reg)
                               ? (sum_e[DATA_WIDTH] ? MIN_NEG : MAX_POS)
                               : sum_e[DATA_WIDTH-1:0];
      end
   endgenerate

   // y_out is deliberately not cleared on accept; out_valid marks stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_reg      <= '0;
         sat_reg       <= 1'b0;
         shift_reg     <= '0;
         y_reg         <= '0;
         out_valid_reg <= 1'b0;
         ovf_reg       <= 1'b0;
      end else if (accept) begin
         beat_reg      <= '0;
         sat_reg       <= sat_en;
         shift_reg     <= sub_shift;
         out_valid_reg <= 1'b0;
         ovf_reg       <= 1'b0;
      end else if (state_reg == ADD) begin
         for (int l = 0; l < LANES; l++) begin
            y_reg[(int'(beat_reg) * LANES + l) * DATA_WIDTH +: DATA_WIDTH] <= lane_y[l];
         end
         ovf_reg <= ovf_reg | (|lane_ovf);
         if (last_beat) out_valid_reg <= 1'b1;
         else           beat_reg      <= beat_reg + 1'b1;
      end
   end

   assign y_out     = y_reg;
   assign out_valid = out_valid_reg;
   assign ovf       = ovf_reg;

endmodule

// File: tb/tb_residual_lane_sat.sv
// Self-checking bench for residual_lane_sat: directed vector table, multi-cycle
// handshake/reset sequences, and randomised passes against an integer model.
module tb_residual_lane_sat;
   localparam int DW = 16;
   localparam int SL = 8;
   localparam int ED = 8;
   localparam int LN = 4;
   localparam int N  = SL * ED;
   localparam int NB = N / LN;
   localparam int SW = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              sat_en = 1'b0;
   logic [SW-1:0]     sub_shift = '0;
   logic [DW*N-1:0]   x_in = '0;
   logic [DW*N-1:0]   sub_in = '0;
   logic [DW*N-1:0]   y_out;
   logic              busy, done, out_valid, ovf;

   int compared   = 0;
   int mismatched = 0;

   logic [15:0] xv [N];
   logic [15:0] sv [N];
   logic [15:0] exp_y [N];
   bit          exp_bo [NB];

   typedef struct {
      string       name;
      bit          sat;
      int          shift;
      logic [15:0] xb, xs, sb, ss, yb, ys;
      bit          o;
   } vec_t;

   vec_t vecs [7];

   residual_lane_sat #(
      .DATA_WIDTH(DW), .SEQ_LEN(SL), .EMB_DIM(ED), .LANES(LN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sat_en(sat_en),
      .sub_shift(sub_shift), .x_in(x_in), .sub_in(sub_in), .y_out(y_out),
      .busy(busy), .done(done), .out_valid(out_valid), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic load_inputs();
      for (int k = 0; k < N; k++) begin
         x_in[k*DW +: DW]   = xv[k];
         sub_in[k*DW +: DW] = sv[k];
      end
   endtask

   // Reference: plain integer arithmetic on the signed values.
   function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] s,
                                           input int sh, input bit sat, output bit o);
      int xi, si, sum;
      xi  = int'($signed(x));
      si  = int'($signed(s)) >>> sh;
      sum = xi + si;
      o   = (sum > 32767) || (sum < -32768);
      if (o && sat) return (sum > 0) ? 16'h7FFF : 16'h8000;
      return 16'(sum);
   endfunction

   task automatic model(input bit sat, input int sh);
      bit o;
      for (int b = 0; b < NB; b++) exp_bo[b] = 1'b0;
      for (int k = 0; k < N; k++) begin
         exp_y[k] = ref_add(xv[k], sv[k], sh, sat, o);
         if (o) exp_bo[k / LN] = 1'b1;
      end
   endtask

   task automatic check_y(input string name);
      int bad = -1;
      for (int k = 0; k < N; k++)
         if (bad < 0 && y_out[k*DW +: DW] !== exp_y[k]) bad = k;
      if (bad < 0) bad = 0;
      check($sformatf("%s y[%0d]", name, bad), 32'(y_out[bad*DW +: DW]), 32'(exp_y[bad]));
   endtask

   task automatic launch(input bit hold);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   // Called at the negedge right after the accept edge.
   task automatic wait_done(input string name, input int start_poke, input int cfg_poke,
                            input bit check_fall);
      int lat = 0;
      int bc  = 0;
      bit trace_ok = 1'b1;
      bit acc_o, all_o;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bc++;
         acc_o = 1'b0;
         for (int b = 0; b < lat && b < NB; b++) acc_o |= exp_bo[b];
         if (ovf !== acc_o) trace_ok = 1'b0;
         if (lat == start_poke) start = 1'b1;
         else if (start_poke >= 0 && lat == start_poke + 1) start = 1'b0;
         if (lat == cfg_poke) begin
            sat_en    = ~sat_en;
            sub_shift = '0;
         end
         @(negedge clk);
         lat++;
      end
      all_o = 1'b0;
      for (int b = 0; b < NB; b++) all_o |= exp_bo[b];
      check({name, " latency"}, lat, NB);
      check({name, " busy_cycles"}, bc, NB);
      check({name, " ovf_trace"}, 32'(trace_ok), 1);
      check({name, " busy_at_done"}, 32'(busy), 0);
      check({name, " out_valid"}, 32'(out_valid), 1);
      check({name, " ovf"}, 32'(ovf), 32'(all_o));
      check_y(name);
      if (check_fall) begin
         @(negedge clk);
         check({name, " done_width"}, 32'(done), 0);
         check({name, " out_valid_hold"}, 32'(out_valid), 1);
         check({name, " ovf_hold"}, 32'(ovf), 32'(all_o));
      end
   endtask

   task automatic fill_const(input logic [15:0] x, input logic [15:0] s);
      for (int k = 0; k < N; k++) begin
         xv[k] = x;
         sv[k] = s;
      end
   endtask

   task automatic fill_ramp();
      for (int k = 0; k < N; k++) begin
         xv[k] = 16'(k);
         sv[k] = 16'(2 * k);
      end
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"wrap_ramp",   1'b0, 0,  16'h0000, 16'h0001, 16'h0000, 16'h0002, 16'h0000, 16'h0003, 1'b0};
      vecs[1] = '{"sat_pos",     1'b1, 0,  16'h7FF0, 16'h0000, 16'h0020, 16'h0000, 16'h7FFF, 16'h0000, 1'b1};
      vecs[2] = '{"wrap_pos",    1'b0, 0,  16'h7FF0, 16'h0000, 16'h0020, 16'h0000, 16'h8010, 16'h0000, 1'b1};
      vecs[3] = '{"sat_neg",     1'b1, 0,  16'h8000, 16'h0000, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000, 1'b1};
      vecs[4] = '{"wrap_neg",    1'b0, 0,  16'h8000, 16'h0000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h0000, 1'b1};
      vecs[5] = '{"shift2",      1'b0, 2,  16'h000A, 16'h0000, 16'hFFF8, 16'h0000, 16'h0008, 16'h0000, 1'b0};
      vecs[6] = '{"shift15",     1'b1, 15, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b0};

      // Reset state, observed while rst_n is still low.
      #12;
      check("reset y_zero", 32'(y_out === '0), 1);
      check("reset busy", 32'(busy), 0);
      check("reset done", 32'(done), 0);
      check("reset out_valid", 32'(out_valid), 0);
      check("reset ovf", 32'(ovf), 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         for (int k = 0; k < N; k++) begin
            xv[k]    = 16'(vecs[i].xb + k * vecs[i].xs);
            sv[k]    = 16'(vecs[i].sb + k * vecs[i].ss);
            exp_y[k] = 16'(vecs[i].yb + k * vecs[i].ys);
         end
         for (int b = 0; b < NB; b++) exp_bo[b] = vecs[i].o;
         sat_en    = vecs[i].sat;
         sub_shift = SW'(vecs[i].shift);
         load_inputs();
         launch(1'b0);
         wait_done(vecs[i].name, -1, -1, 1'b1);
      end

      // start pulsed mid-pass must not restart or clear ovf.
      fill_const(16'h7FF0, 16'h0020);
      sat_en = 1'b1; sub_shift = '0;
      load_inputs(); model(1'b1, 0);
      launch(1'b0);
      wait_done("ign_start", 5, -1, 1'b1);

      // Config changes after accept must not affect the running pass.
      fill_const(16'h000A, 16'hFFF8);
      sat_en = 1'b0; sub_shift = SW'(2);
      load_inputs(); model(1'b0, 2);
      launch(1'b0);
      wait_done("cfg_poke", -1, 3, 1'b1);

      // Back-to-back: start held through the done cycle.
      fill_const(16'h7FF0, 16'h0020);
      sat_en = 1'b1; sub_shift = '0;
      load_inputs(); model(1'b1, 0);
      launch(1'b1);
      wait_done("b2b_first", -1, -1, 1'b0);
      fill_ramp();
      sat_en = 1'b0; sub_shift = '0;
      load_inputs(); model(1'b0, 0);
      @(negedge clk);
      start = 1'b0;
      check("b2b done_fall", 32'(done), 0);
      check("b2b out_valid_clear", 32'(out_valid), 0);
      check("b2b ovf_clear", 32'(ovf), 0);
      check("b2b busy", 32'(busy), 1);
      wait_done("b2b_second", -1, -1, 1'b1);

      // Asynchronous reset during beat 7.
      fill_const(16'h7FF0, 16'h0020);
      sat_en = 1'b1; sub_shift = '0;
      load_inputs(); model(1'b1, 0);
      launch(1'b0);
      repeat (7) @(negedge clk);
      check("midrst ovf_before", 32'(ovf), 1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst y_zero", 32'(y_out === '0), 1);
      check("midrst busy", 32'(busy), 0);
      check("midrst done", 32'(done), 0);
      check("midrst out_valid", 32'(out_valid), 0);
      check("midrst ovf", 32'(ovf), 0);
      @(negedge clk);
      rst_n = 1'b1;
      fill_ramp();
      sat_en = 1'b0; sub_shift = '0;
      load_inputs(); model(1'b0, 0);
      launch(1'b0);
      wait_done("after_rst", -1, -1, 1'b1);

      // Randomised passes; every fourth uses small data with one hot spot
      // so ovf rises part-way through the pass.
      for (int p = 0; p < 200; p++) begin
         bit rs;
         int rsh;
         rs  = 1'($urandom_range(0, 1));
         rsh = int'($urandom_range(0, 15));
         for (int k = 0; k < N; k++) begin
            if (p % 4 == 0) begin
               xv[k] = 16'(int'($urandom_range(0, 2000)) - 1000);
               sv[k] = 16'(int'($urandom_range(0, 2000)) - 1000);
            end else begin
               xv[k] = 16'($urandom);
               sv[k] = 16'($urandom);
            end
         end
         if (p % 4 == 0) begin
            int k0;
            k0 = int'($urandom_range(0, N - 1));
            xv[k0] = 16'h7F00;
            sv[k0] = 16'h7F00;
            rsh = 0;
         end
         sat_en    = rs;
         sub_shift = SW'(rsh);
         load_inputs(); model(rs, rsh);
         launch(1'b0);
         wait_done($sformatf("rand%0d", p), -1, -1, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
